hight_kat_sequencer: RTL and testbench
======================================

# hight_kat_sequencer

Synthesizable known-answer-test (KAT) sequencer for the `hight` cipher core. It reads test vectors from a synchronous ROM and drives the core's plaintext, master-key, mode and reset inputs. It waits a parametrised latency, compares the core output against the expected value, and reports pass/fail, an error count and the first failing index. It sits beside `hight` as an on-chip self-test. It extends single-mode checking with encrypt, decrypt and round-trip modes, plus a configurable vector count and latency.

## Interface
- `NUM_VEC`, 241: number of ROM vectors, indices 0..NUM_VEC-1.
- `AW`, 8: ROM address width. Must satisfy 2^AW >= NUM_VEC.
- `DUT_LATENCY`, 35: cycles from the cycle after `dut_reset` falls to the valid `dut_c` sample.
- `RST_CYC`, 2: cycles `dut_reset` is held high per operation. Must be >= 1.
- `MODE`, 0: 0 = encrypt only, 1 = decrypt only, 2 = both (encrypt then decrypt per vector).

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; honoured only in IDLE or DONE.
- `rom_addr` out AW: vector index. `rom_data` is valid one cycle later.
- `rom_data` in 256: vector `{MK[255:128], P[127:64], EXP[63:0]}`.
- `dut_reset` out 1: drives the `hight` reset.
- `dut_ed` out 1: 1 = encrypt, 0 = decrypt.
- `dut_p` out 64: core data input.
- `dut_mk` out 128: core master key.
- `dut_c` in 64: core output.
- `busy` out 1: high from the cycle after an accepted `start` until DONE.
- `done` out 1: high in DONE.
- `pass` out 1: valid when `done`; 1 iff `err_count == 0`.
- `err_count` out 16: failing operations; saturates at 16'hFFFF.
- `first_err_valid` out 1: set at the first mismatch.
- `first_err_idx` out AW: vector index of the first mismatch.

## Operation
- States: IDLE, FETCH, LOAD, RUN, CHECK, DONE. Internal registers: `idx`, `pass2` (second-pass flag), `cnt`.
- Reset values: state IDLE, `rom_addr` 0, `dut_reset` 1, `dut_ed` 1, `dut_p` 0, `dut_mk` 0, `busy`/`done`/`pass` 0, `err_count` 0, `first_err_valid` 0, `first_err_idx` 0.
- IDLE/DONE + `start`:
  - Clear `err_count`, `first_err_*`, `idx`, `pass2` and `done`.
  - Go to FETCH; `rom_addr` = 0.
- FETCH (1 cycle): `rom_addr` = `idx`. Go to LOAD.
- LOAD (`RST_CYC` cycles): `dut_reset` = 1. On the first LOAD cycle, latch `rom_data` into the MK/P/EXP registers, then drive:
  - Encrypt pass: `dut_ed` = 1, `dut_p` = P, expected = EXP.
  - Decrypt pass: `dut_ed` = 0, `dut_p` = EXP, expected = P.
  - MODE 0 uses only the encrypt pass; MODE 1 only the decrypt pass.
  - MODE 2: encrypt pass with `pass2` = 0, then decrypt pass with `pass2` = 1.
- RUN (`DUT_LATENCY` cycles): `dut_reset` = 0; `cnt` counts 1..DUT_LATENCY.
- CHECK (1 cycle): compare `dut_c` with expected using 4-state `!==` semantics in simulation; X counts as mismatch.
  - On mismatch: `err_count` += 1 (saturating). If `first_err_valid` is 0, set it and load `first_err_idx` = `idx`.
  - Next state, in priority order:
    - MODE 2 and `pass2` = 0: set `pass2` = 1, go to LOAD. No refetch; latched vector reused.
    - Else if `idx == NUM_VEC-1`: go to DONE.
    - Else: `idx` += 1, `pass2` = 0, go to FETCH.
- DONE: `dut_reset` = 1, `busy` = 0, `done` = 1, `pass` = (`err_count == 0`). Hold until `start` or `reset`.
- `dut_p`/`dut_mk`/`dut_ed` are stable through LOAD, RUN and CHECK.
- `start` while busy is ignored.
- `reset` asserted mid-run: abort and return to reset values on the next edge. The vector in progress is not counted.
- `dut_reset` is high in every state except RUN.

## Timing
- Cycles per operation:
  - First pass of a vector: 1 + `RST_CYC` + `DUT_LATENCY` + 1. Defaults: 39.
  - MODE 2 second pass: `RST_CYC` + `DUT_LATENCY` + 1 = 38.
- Total from `start` edge to `done` = 1:
  - MODE 0 or 1: NUM_VEC × 39 + 1 cycles.
  - MODE 2: NUM_VEC × 77 + 1 cycles.
- `dut_c` is sampled on the edge ending the last RUN cycle, i.e. `DUT_LATENCY` edges after `dut_reset` falls.
- `err_count` and `first_err_*` update on the edge leaving CHECK.

## Test plan
- Single vector, MODE 0, stub DUT returns the expected value after 35 cycles. ROM[0] = key 00112233445566778899aabbccddeeff, P 0, EXP 00f418aed94f03f2. Required: `done` after 40 cycles, `pass` = 1, `err_count` = 0, `dut_ed` = 1.
- MODE 2, same vector, real `hight` core:
  - Two operations with `dut_ed` 1 then 0.
  - Decrypt pass drives `dut_p` = 00f418aed94f03f2 and expects 0.
  - `pass` = 1; total 78 cycles.
- Error capture: NUM_VEC = 4, vectors 1 and 3 corrupted (EXP bit 0 flipped). Required: `err_count` = 2, `first_err_idx` = 1, `pass` = 0.
- Latency boundary: stub DUT presents its result one cycle late (DUT_LATENCY + 1). Required: every operation fails, `err_count` = NUM_VEC.
- Reset mid-run: assert `reset` in RUN of vector 2 (NUM_VEC = 4). Required: all outputs return to reset values the next cycle. A new `start` reruns from `idx` 0 and passes.
- `start` pulsed during RUN: ignored (`idx` sequence unchanged). `start` in DONE: counters cleared and run repeats with identical results.

Source files
------------

// File: rtl/hight_kat_sequencer.sv
// Known-answer-test sequencer for the hight cipher core: walks a vector ROM,
// runs each vector through the core in encrypt/decrypt passes and tallies mismatches.
module hight_kat_sequencer #(
    parameter int unsigned NUM_VEC     = 241,
    parameter int unsigned AW          = 8,
    parameter int unsigned DUT_LATENCY = 35,
    parameter int unsigned RST_CYC     = 2,
    parameter int unsigned MODE        = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [AW-1:0]   rom_addr,
    input  logic [255:0]    rom_data,
    output logic            dut_reset,
    output logic            dut_ed,
    output logic [63:0]     dut_p,
    output logic [127:0]    dut_mk,
    input  logic [63:0]     dut_c,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     err_count,
    output logic            first_err_valid,
    output logic [AW-1:0]   first_err_idx
);

    localparam int unsigned CNT_MAX  = (DUT_LATENCY > RST_CYC) ? DUT_LATENCY : RST_CYC;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [AW-1:0]  idx;
    logic           pass2;
    logic [127:0]   mk_q;
    logic [63:0]    p_q;
    logic [63:0]    exp_q;
    logic [63:0]    expect_q;
    logic           mis_q;

    logic           accept_c;
    logic           first_load_c;
    logic           decrypt_c;
    logic [127:0]   src_mk_c;
    logic [63:0]    src_p_c;
    logic [63:0]    src_exp_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_FETCH;
            S_FETCH:        state_next = S_LOAD;
            S_LOAD:         if (cnt == CW'(RST_CYC - 1)) state_next = S_RUN;
            S_RUN:          if (cnt == CW'(DUT_LATENCY)) state_next = S_CHECK;
            S_CHECK: begin
                if (MODE == 2 && !pass2) begin
                    state_next = S_LOAD;
                end else if (idx == LAST_IDX) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            default:        state_next = S_IDLE;
        endcase
    end

    // Second pass of a vector reuses the latched copy instead of refetching.
    always_comb begin
        accept_c     = (state == S_IDLE || state == S_DONE) && start;
        first_load_c = (state == S_LOAD) && (cnt == '0);
        decrypt_c    = (MODE == 1) || pass2;
        src_mk_c     = pass2 ? mk_q  : rom_data[255:128];
        src_p_c      = pass2 ? p_q   : rom_data[127:64];
        src_exp_c    = pass2 ? exp_q : rom_data[63:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= (state_next == S_RUN) ? CW'(1) : '0;
        end else if (state == S_LOAD || state == S_RUN) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr        <= '0;
            dut_reset       <= 1'b1;
            dut_ed          <= 1'b1;
            dut_p           <= '0;
            dut_mk          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            idx             <= '0;
            pass2           <= 1'b0;
            mk_q            <= '0;
            p_q             <= '0;
            exp_q           <= '0;
            expect_q        <= '0;
            mis_q           <= 1'b0;
        end else begin
            dut_reset <= (state_next != S_RUN);

            if (accept_c) begin
                rom_addr        <= '0;
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
                idx             <= '0;
                pass2           <= 1'b0;
                busy            <= 1'b1;
                done            <= 1'b0;
                pass            <= 1'b0;
            end else if (state == S_DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_count == 16'd0);
            end

            if (first_load_c) begin
                if (!pass2) begin
                    mk_q  <= rom_data[255:128];
                    p_q   <= rom_data[127:64];
                    exp_q <= rom_data[63:0];
                end
                dut_mk   <= src_mk_c;
                dut_ed   <= !decrypt_c;
                dut_p    <= decrypt_c ? src_exp_c : src_p_c;
                expect_q <= decrypt_c ? src_p_c : src_exp_c;
            end

            // X or Z on the core output must register as a failure.
            if (state == S_RUN && cnt == CW'(DUT_LATENCY)) begin
                mis_q <= (dut_c !== expect_q);
            end

            if (state == S_CHECK) begin
                if (mis_q) begin
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= idx;
                    end
                end
                if (MODE == 2 && !pass2) begin
                    pass2 <= 1'b1;
                end else if (idx != LAST_IDX) begin
                    idx      <= idx + AW'(1);
                    rom_addr <= idx + AW'(1);
                    pass2    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hight_kat_sequencer.sv
// Bench for hight_kat_sequencer: three instances (encrypt, decrypt, round-trip)
// share a random vector ROM and an invertible stub core with adjustable latency.
module tb_hight_kat_sequencer;

    localparam int NV  = 4;
    localparam int LAT = 35;
    localparam int RC  = 2;
    localparam int MID = 2 * (1 + RC + LAT + 1) + 20;
    localparam logic [229:0] RST_VAL = {8'h00, 1'b1, 1'b1, 64'h0, 128'h0,
                                        3'b000, 16'h0000, 1'b0, 8'h00};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic [2:0][7:0]   rom_addr_v;
    logic [2:0][255:0] rom_data_v;
    logic [2:0]        dut_reset_v;
    logic [2:0]        dut_ed_v;
    logic [2:0][63:0]  dut_p_v;
    logic [2:0][127:0] dut_mk_v;
    logic [2:0][63:0]  dut_c_v;
    logic [2:0]        busy_v;
    logic [2:0]        done_v;
    logic [2:0]        pass_v;
    logic [2:0][15:0]  err_v;
    logic [2:0]        fev_v;
    logic [2:0][7:0]   fei_v;

    logic [255:0] rom_mem [NV];
    int           stub_lat = LAT;
    int           stub_cnt [3];
    logic [192:0] op_log [3][16];
    int           op_n [3];
    logic [2:0]   rst_d = 3'b111;
    logic         log_clr = 1'b0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hight_kat_sequencer #(
            .NUM_VEC(NV), .AW(8), .DUT_LATENCY(LAT), .RST_CYC(RC), .MODE(g)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .start(start),
            .rom_addr(rom_addr_v[g]),
            .rom_data(rom_data_v[g]),
            .dut_reset(dut_reset_v[g]),
            .dut_ed(dut_ed_v[g]),
            .dut_p(dut_p_v[g]),
            .dut_mk(dut_mk_v[g]),
            .dut_c(dut_c_v[g]),
            .busy(busy_v[g]),
            .done(done_v[g]),
            .pass(pass_v[g]),
            .err_count(err_v[g]),
            .first_err_valid(fev_v[g]),
            .first_err_idx(fei_v[g])
        );
    end

    // Toy invertible cipher standing in for hight: decrypt undoes encrypt.
    function automatic logic [63:0] core(input logic [127:0] mk, input logic [63:0] d,
                                         input logic ed);
        logic [63:0] k;
        k = mk[127:64] ^ {mk[31:0], mk[63:32]};
        return ed ? d + k : d - k;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) begin
            rom_data_v[m] <= (rom_addr_v[m] < 8'(NV)) ? rom_mem[rom_addr_v[m][1:0]] : '0;
            stub_cnt[m]   <= dut_reset_v[m] ? 0 : stub_cnt[m] + 1;
        end
    end

    // Stub core: correct result only once stub_lat edges have passed since reset fell.
    always_comb begin
        for (int m = 0; m < 3; m++) begin
            dut_c_v[m] = (stub_cnt[m] + 1 >= stub_lat)
                       ? core(dut_mk_v[m], dut_p_v[m], dut_ed_v[m])
                       : ~core(dut_mk_v[m], dut_p_v[m], dut_ed_v[m]);
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (log_clr) begin
                op_n[m] <= 0;
            end else if (rst_d[m] && !dut_reset_v[m] && op_n[m] < 16) begin
                op_log[m][op_n[m]] <= {dut_ed_v[m], dut_p_v[m], dut_mk_v[m]};
                op_n[m] <= op_n[m] + 1;
            end
            rst_d[m] <= dut_reset_v[m];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom(input logic [NV-1:0] bad);
        logic [127:0] mk;
        logic [63:0]  p;
        for (int v = 0; v < NV; v++) begin
            mk = {$urandom, $urandom, $urandom, $urandom};
            p  = {$urandom, $urandom};
            if (v == 0) begin
                mk = 128'h00112233445566778899aabbccddeeff;
                p  = 64'h0;
            end
            rom_mem[v] = {mk, p, core(mk, p, 1'b1) ^ 64'(bad[v])};
        end
    endtask

    task automatic run_scenario(input string name, input bit pulse_mid);
        int           done_at [3];
        int           exp_cyc;
        int           exp_err;
        int           exp_fei;
        int           nops;
        bit           exp_fev;
        logic [192:0] exp_op [16];
        logic [127:0] mk;
        logic [63:0]  din;
        logic [63:0]  want;
        logic         ed;
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int m = 0; m < 3; m++) done_at[m] = -1;
        for (int k = 1; k <= NV * 77 + 20; k++) begin
            start = pulse_mid && (k == MID);
            tick();
            for (int m = 0; m < 3; m++) begin
                if (done_v[m] && done_at[m] < 0) done_at[m] = k;
            end
            if (done_at[0] >= 0 && done_at[1] >= 0 && done_at[2] >= 0) break;
        end
        start = 1'b0;
        for (int m = 0; m < 3; m++) begin
            exp_cyc = (m == 2) ? NV * ((1 + RC + LAT + 1) + (RC + LAT + 1)) + 1
                               : NV * (1 + RC + LAT + 1) + 1;
            exp_err = 0;
            exp_fev = 1'b0;
            exp_fei = 0;
            nops    = 0;
            for (int v = 0; v < NV; v++) begin
                for (int ps = 0; ps < ((m == 2) ? 2 : 1); ps++) begin
                    ed   = (m == 0) || (m == 2 && ps == 0);
                    mk   = rom_mem[v][255:128];
                    din  = ed ? rom_mem[v][127:64] : rom_mem[v][63:0];
                    want = ed ? rom_mem[v][63:0] : rom_mem[v][127:64];
                    exp_op[nops] = {ed, din, mk};
                    nops++;
                    if (stub_lat != LAT || core(mk, din, ed) !== want) begin
                        exp_err++;
                        if (!exp_fev) begin
                            exp_fev = 1'b1;
                            exp_fei = v;
                        end
                    end
                end
            end
            checks++;
            if (done_at[m] !== exp_cyc) begin
                errors++;
                $display("FAIL %s mode%0d done_cycle: got %0d want %0d", name, m, done_at[m], exp_cyc);
            end
            checks++;
            if (err_v[m] !== 16'(exp_err)) begin
                errors++;
                $display("FAIL %s mode%0d err_count: got %0d want %0d", name, m, err_v[m], exp_err);
            end
            checks++;
            if (pass_v[m] !== (exp_err == 0)) begin
                errors++;
                $display("FAIL %s mode%0d pass: got %b want %b", name, m, pass_v[m], exp_err == 0);
            end
            checks++;
            if (fev_v[m] !== exp_fev) begin
                errors++;
                $display("FAIL %s mode%0d first_err_valid: got %b want %b", name, m, fev_v[m], exp_fev);
            end
            if (exp_fev) begin
                checks++;
                if (fei_v[m] !== 8'(exp_fei)) begin
                    errors++;
                    $display("FAIL %s mode%0d first_err_idx: got %0d want %0d", name, m, fei_v[m], exp_fei);
                end
            end
            checks++;
            if ({busy_v[m], dut_reset_v[m]} !== 2'b01) begin
                errors++;
                $display("FAIL %s mode%0d busy_dutreset_in_done: got %b%b want 01", name, m, busy_v[m], dut_reset_v[m]);
            end
            checks++;
            if (op_n[m] !== nops) begin
                errors++;
                $display("FAIL %s mode%0d op_count: got %0d want %0d", name, m, op_n[m], nops);
            end
            for (int i = 0; i < nops && i < op_n[m]; i++) begin
                checks++;
                if (op_log[m][i] !== exp_op[i]) begin
                    errors++;
                    $display("FAIL %s mode%0d op%0d {ed,p,mk}: got %h want %h", name, m, i, op_log[m][i], exp_op[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [229:0] got;
        reset = 1'b1;
        tick();
        tick();
        for (int m = 0; m < 3; m++) begin
            got = {rom_addr_v[m], dut_reset_v[m], dut_ed_v[m], dut_p_v[m], dut_mk_v[m],
                   busy_v[m], done_v[m], pass_v[m], err_v[m], fev_v[m], fei_v[m]};
            checks++;
            if (got !== RST_VAL) begin
                errors++;
                $display("FAIL reset mode%0d outputs: got %h want %h", m, got, RST_VAL);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_clean();
        fill_rom('0);
        run_scenario("clean", 1'b0);
    endtask

    task automatic test_errors();
        fill_rom(4'b1010);
        run_scenario("err_1010", 1'b0);
        fill_rom(4'($urandom_range(0, 15)));
        run_scenario("err_random", 1'b0);
    endtask

    task automatic test_late_latency();
        fill_rom('0);
        stub_lat = LAT + 1;
        run_scenario("late_result", 1'b0);
        stub_lat = LAT;
    endtask

    task automatic test_reset_mid_run();
        logic [229:0] got;
        fill_rom('0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < MID; k++) tick();
        reset = 1'b1;
        tick();
        for (int m = 0; m < 3; m++) begin
            got = {rom_addr_v[m], dut_reset_v[m], dut_ed_v[m], dut_p_v[m], dut_mk_v[m],
                   busy_v[m], done_v[m], pass_v[m], err_v[m], fev_v[m], fei_v[m]};
            checks++;
            if (got !== RST_VAL) begin
                errors++;
                $display("FAIL midrun_reset mode%0d outputs: got %h want %h", m, got, RST_VAL);
            end
        end
        reset = 1'b0;
        tick();
        run_scenario("after_reset", 1'b0);
    endtask

    task automatic test_start_ignored();
        fill_rom(4'($urandom_range(0, 15)));
        run_scenario("start_in_run", 1'b1);
    endtask

    task automatic test_restart_in_done();
        fill_rom(4'b0100);
        run_scenario("run_once", 1'b0);
        run_scenario("rerun_from_done", 1'b0);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_errors();
        test_late_latency();
        test_reset_mid_run();
        test_start_ignored();
        test_restart_in_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
